// File: rtl/glb_cfg_arbiter.sv
// glb_cfg_arbiter: two-requester (glc, jtag) round-robin arbiter onto the GLB
// config write/read strobe interface, one transaction in flight at a time.
// Optional feature macro: GLB_CFG_ARB_TIMEOUT_EN enables the read-response
// timeout (RD_TIMEOUT cycles in RD_WAIT -> error response).
module glb_cfg_arbiter #(
    parameter int unsigned AXI_ADDR_WIDTH = 12,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned RD_TIMEOUT     = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [1:0]                  req_vld,
    output logic [1:0]                  req_rdy,
    input  logic [1:0]                  req_wr,
    input  logic [2*AXI_ADDR_WIDTH-1:0] req_addr,
    input  logic [2*AXI_DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]                  rsp_vld,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic                        rsp_err,
    output logic                        if_cfg_wr_en,
    output logic                        if_cfg_wr_clk_en,
    output logic [AXI_ADDR_WIDTH-1:0]   if_cfg_wr_addr,
    output logic [AXI_DATA_WIDTH-1:0]   if_cfg_wr_data,
    output logic                        if_cfg_rd_en,
    output logic                        if_cfg_rd_clk_en,
    output logic [AXI_ADDR_WIDTH-1:0]   if_cfg_rd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   if_cfg_rd_data,
    input  logic                        if_cfg_rd_data_valid
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ISSUE = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RESP     = 3'd4
    } state_t;

    // Elaboration-time guard on the legal timeout range
    if (RD_TIMEOUT < 2 || RD_TIMEOUT > 1024) begin : g_bad_timeout
        $error("glb_cfg_arbiter: RD_TIMEOUT must be within 2..1024");
    end

    state_t                      state;
    state_t                      state_nxt;
    logic                        own_q;      // requester owning the transaction
    logic                        prio_q;     // requester favoured when both are valid
    logic                        gnt;
    logic                        hs;
    logic                        sel_wr;
    logic [AXI_ADDR_WIDTH-1:0]   sel_addr;
    logic [AXI_DATA_WIDTH-1:0]   sel_wdata;
    logic [AXI_DATA_WIDTH-1:0]   rsp_rdata_nxt;

`ifdef GLB_CFG_ARB_TIMEOUT_EN
    localparam int unsigned CW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

    logic [CW-1:0] to_cnt;
    logic          to_hit;
    logic          rsp_err_nxt;

    assign to_hit = (state == RD_WAIT) && (to_cnt == CW'(RD_TIMEOUT - 1));

    // Count cycles spent in RD_WAIT; cleared in every other state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (state == RD_WAIT) begin
            to_cnt <= to_cnt + CW'(1);
        end else begin
            to_cnt <= '0;
        end
    end

    // Registered error flag of the response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_err <= 1'b0;
        end else begin
            rsp_err <= rsp_err_nxt;
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Round-robin grant, combinational ready in IDLE, next state and response data
    always_comb begin
        state_nxt     = state;
        req_rdy       = 2'b00;
        hs            = 1'b0;
        rsp_rdata_nxt = '0;
`ifdef GLB_CFG_ARB_TIMEOUT_EN
        rsp_err_nxt   = 1'b0;
`endif
        gnt       = (req_vld == 2'b11) ? prio_q : req_vld[1];
        sel_wr    = gnt ? req_wr[1] : req_wr[0];
        sel_addr  = gnt ? req_addr[2*AXI_ADDR_WIDTH-1:AXI_ADDR_WIDTH]
                        : req_addr[AXI_ADDR_WIDTH-1:0];
        sel_wdata = gnt ? req_wdata[2*AXI_DATA_WIDTH-1:AXI_DATA_WIDTH]
                        : req_wdata[AXI_DATA_WIDTH-1:0];
        case (state)
            IDLE: begin
                if (req_vld != 2'b00) begin
                    req_rdy   = {gnt, ~gnt};
                    hs        = 1'b1;
                    state_nxt = sel_wr ? WR_ISSUE : RD_ISSUE;
                end
            end
            WR_ISSUE: state_nxt = RESP;
            RD_ISSUE, RD_WAIT: begin
                if (if_cfg_rd_data_valid) begin
                    state_nxt     = RESP;
                    rsp_rdata_nxt = if_cfg_rd_data;
                end
`ifdef GLB_CFG_ARB_TIMEOUT_EN
                else if (to_hit) begin
                    state_nxt   = RESP;
                    rsp_err_nxt = 1'b1;
                end
`endif
                else if (state == RD_ISSUE) begin
                    state_nxt = RD_WAIT;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture and registered GLB strobes / response outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            own_q            <= 1'b0;
            prio_q           <= 1'b0;
            if_cfg_wr_addr   <= '0;
            if_cfg_wr_data   <= '0;
            if_cfg_rd_addr   <= '0;
            if_cfg_wr_en     <= 1'b0;
            if_cfg_wr_clk_en <= 1'b0;
            if_cfg_rd_en     <= 1'b0;
            if_cfg_rd_clk_en <= 1'b0;
            rsp_vld          <= 2'b00;
            rsp_rdata        <= '0;
        end else begin
            if (hs) begin
                own_q  <= gnt;
                prio_q <= ~gnt;
                if (sel_wr) begin
                    if_cfg_wr_addr <= sel_addr;
                    if_cfg_wr_data <= sel_wdata;
                end else begin
                    if_cfg_rd_addr <= sel_addr;
                end
            end
            if_cfg_wr_en     <= (state_nxt == WR_ISSUE);
            if_cfg_wr_clk_en <= (state_nxt == WR_ISSUE) || (state == WR_ISSUE);
            if_cfg_rd_en     <= (state_nxt == RD_ISSUE);
            if_cfg_rd_clk_en <= (state_nxt == RD_ISSUE) || (state_nxt == RD_WAIT);
            rsp_vld          <= (state_nxt == RESP) ? {own_q, ~own_q} : 2'b00;
            rsp_rdata        <= rsp_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_glb_cfg_arbiter.sv
// Self-checking bench for glb_cfg_arbiter: per-cycle transaction-level model
// plus directed scenarios with literal expectations. Honours GLB_CFG_ARB_TIMEOUT_EN.
module tb_glb_cfg_arbiter;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;
    localparam int          TO = 8;

    logic          clk;
    logic          reset;
    logic [1:0]    req_vld, req_rdy, req_wr, rsp_vld;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          wr_en, wr_clk_en, rd_en, rd_clk_en, rd_valid;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data, rd_data;

    int cyc = 0;
    int n_checks = 0;
    int n_err = 0;

    glb_cfg_arbiter #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .RD_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_vld(rsp_vld), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .if_cfg_wr_en(wr_en), .if_cfg_wr_clk_en(wr_clk_en),
        .if_cfg_wr_addr(wr_addr), .if_cfg_wr_data(wr_data),
        .if_cfg_rd_en(rd_en), .if_cfg_rd_clk_en(rd_clk_en),
        .if_cfg_rd_addr(rd_addr), .if_cfg_rd_data(rd_data),
        .if_cfg_rd_data_valid(rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Grant rule: both valid -> favoured requester, otherwise the lone valid one
    function automatic logic [1:0] rr(input logic [1:0] v, input logic p);
        if (v == 2'b11) return p ? 2'b10 : 2'b01;
        return v;
    endfunction

    // Transaction-level model: handshake cycle, completion cycle and captured values
    logic          m_busy, m_own, m_wr, m_prio, m_err;
    int            m_hs, m_done;
    logic [DW-1:0] m_rdata, m_wd;
    logic [AW-1:0] m_wa, m_ra;

    task automatic model_reset();
        m_busy = 0; m_own = 0; m_wr = 0; m_prio = 0; m_err = 0;
        m_hs = -100; m_done = -1; m_rdata = '0; m_wd = '0; m_wa = '0; m_ra = '0;
    endtask

    initial model_reset();

    // Compare DUT against the model on every falling edge, then advance the model
    always @(negedge clk) begin
        int         n;
        int         rsp_c;
        logic [1:0] rdy_e, vld_e;
        n = cyc;
        if (reset) begin
            chk("rst_strobes", {wr_en, wr_clk_en, rd_en, rd_clk_en, rsp_vld, rsp_err, req_rdy}, 64'd0);
            chk("rst_addrs", {wr_addr, rd_addr}, 64'd0);
            chk("rst_data", {wr_data, rsp_rdata}, 64'd0);
            model_reset();
        end else begin
            rdy_e = m_busy ? 2'b00 : rr(req_vld, m_prio);
            rsp_c = m_wr ? m_hs + 2 : ((m_done >= 0) ? m_done + 1 : -1);
            vld_e = (m_busy && n == rsp_c) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
            chk("req_rdy", req_rdy, rdy_e);
            chk("wr_en", wr_en, m_busy && m_wr && n == m_hs + 1);
            chk("wr_clk_en", wr_clk_en, m_busy && m_wr && (n == m_hs + 1 || n == m_hs + 2));
            chk("rd_en", rd_en, m_busy && !m_wr && n == m_hs + 1);
            chk("rd_clk_en", rd_clk_en,
                m_busy && !m_wr && n >= m_hs + 1 && (m_done < 0 || n <= m_done));
            chk("rsp_vld", rsp_vld, vld_e);
            if (vld_e != 2'b00) begin
                chk("rsp_rdata", rsp_rdata, m_rdata);
                chk("rsp_err", rsp_err, m_err);
            end
            chk("wr_addr", wr_addr, m_wa);
            chk("wr_data", wr_data, m_wd);
            chk("rd_addr", rd_addr, m_ra);
            if (!m_busy && (rdy_e & req_vld) != 2'b00) begin
                m_busy = 1; m_own = rdy_e[1]; m_prio = ~rdy_e[1];
                m_wr = req_wr[m_own]; m_hs = n; m_done = -1; m_rdata = '0; m_err = 0;
                if (m_wr) begin
                    m_wa = m_own ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
                    m_wd = m_own ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
                end else begin
                    m_ra = m_own ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
                end
            end else if (m_busy) begin
                if (!m_wr && m_done < 0 && n >= m_hs + 1) begin
                    if (rd_valid) begin
                        m_done = n; m_rdata = rd_data; m_err = 0;
                    end
`ifdef GLB_CFG_ARB_TIMEOUT_EN
                    else if (n == m_hs + 1 + TO) begin
                        m_done = n; m_rdata = '0; m_err = 1;
                    end
`endif
                end
                if (n == rsp_c) m_busy = 0;
            end
        end
    end

    task automatic req_start(input int r, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk); #1;
        req_vld[r] = 1'b1;
        req_wr[r]  = wr;
        if (r == 1) begin req_addr[2*AW-1:AW] = a; req_wdata[2*DW-1:DW] = d; end
        else        begin req_addr[AW-1:0]    = a; req_wdata[DW-1:0]    = d; end
    endtask

    // Wait (bounded) for the handshake of requester r, then drop its valid
    task automatic wait_hs(input int r, output int h);
        h = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (req_rdy[r] && req_vld[r]) begin h = cyc; break; end
        end
        @(posedge clk); #1;
        req_vld[r] = 1'b0;
    endtask

    // Wait (bounded) for a DUT output: 0 wr_en, 1 rd_en, 2 rsp_vld[0], 3 rsp_vld[1]
    task automatic wait_sig(input int which, input int limit, output int at);
        logic hit;
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            case (which)
                0:       hit = wr_en;
                1:       hit = rd_en;
                2:       hit = rsp_vld[0];
                default: hit = rsp_vld[1];
            endcase
            if (hit) begin at = cyc; break; end
        end
    endtask

    task automatic pulse_rd(input logic [DW-1:0] d);
        @(posedge clk); #1;
        rd_valid = 1'b1; rd_data = d;
        @(posedge clk); #1;
        rd_valid = 1'b0; rd_data = '0;
    endtask

    initial begin
        int h, a, b, c, k;
        logic g [4];
        reset = 0; req_vld = 0; req_wr = 0; req_addr = '0; req_wdata = '0;
        rd_valid = 0; rd_data = '0;
        #2 reset = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        chk("init_rsp_vld", rsp_vld, 2'b00);

        // glc write
        req_start(0, 1'b1, 12'h010, 32'hA5A5A5A5);
        wait_hs(0, h);
        wait_sig(0, 5, a);
        chk("t1_wr_lat", 64'(a - h), 64'd1);
        chk("t1_wr_addr", wr_addr, 12'h010);
        chk("t1_wr_data", wr_data, 32'hA5A5A5A5);
        wait_sig(2, 5, b);
        chk("t1_rsp_lat", 64'(b - h), 64'd2);
        chk("t1_rsp_err", rsp_err, 1'b0);

        // jtag read answered 3 cycles after rd_en
        req_start(1, 1'b0, 12'h020, '0);
        wait_hs(1, h);
        wait_sig(1, 5, a);
        chk("t2_rd_lat", 64'(a - h), 64'd1);
        chk("t2_rd_addr", rd_addr, 12'h020);
        repeat (2) @(posedge clk);
        pulse_rd(32'h12345678);
        wait_sig(3, 5, b);
        chk("t2_rsp_lat", 64'(b - a), 64'd4);
        chk("t2_rdata", rsp_rdata, 32'h12345678);

        // both requesters holding valid: alternate grants
        req_wr = 2'b11;
        req_addr = {12'h200, 12'h100};
        req_wdata = {32'h22222222, 32'h11111111};
        @(posedge clk); #1 req_vld = 2'b11;
        k = 0;
        for (int i = 0; i < 60 && k < 4; i++) begin
            @(negedge clk);
            if ((req_vld & req_rdy) != 2'b00) begin
                g[k] = req_rdy[1];
                k++;
                if (k == 4) begin @(posedge clk); #1 req_vld = 2'b00; end
            end
        end
        chk("t3_count", 64'(k), 64'd4);
        chk("t3_order", {g[0], g[1], g[2], g[3]}, 4'b0101);
        repeat (4) @(posedge clk);

        // unanswered read
        req_start(0, 1'b0, 12'h030, '0);
        wait_hs(0, h);
        wait_sig(1, 5, a);
`ifdef GLB_CFG_ARB_TIMEOUT_EN
        wait_sig(2, 20, b);
        chk("t4_to_lat", 64'(b - a), 64'd9);
        chk("t4_to_err", rsp_err, 1'b1);
        chk("t4_to_rdata", rsp_rdata, 32'd0);
        pulse_rd(32'hDEADBEEF);
        wait_sig(2, 5, c);
        chk("t4_stray_ignored", 64'(c), 64'(-1));
`else
        wait_sig(2, 20, b);
        chk("t4_no_timeout", 64'(b), 64'(-1));
        pulse_rd(32'hCAFE0001);
        wait_sig(2, 5, c);
        chk("t4_late_rdata", rsp_rdata, 32'hCAFE0001);
        chk("t4_late_err", rsp_err, 1'b0);
`endif
        repeat (2) @(posedge clk);

        // reset during RD_WAIT
        req_start(0, 1'b0, 12'h040, '0);
        wait_hs(0, h);
        wait_sig(1, 5, a);
        @(posedge clk);
        #3 reset = 1;
        #1;
        chk("t5_rst_strobes", {wr_en, wr_clk_en, rd_en, rd_clk_en, rsp_vld, rsp_err}, 64'd0);
        chk("t5_rst_addrs", {wr_addr, rd_addr}, 64'd0);
        chk("t5_rst_data", {wr_data, rsp_rdata}, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 0;
        repeat (3) @(posedge clk);
        req_start(1, 1'b1, 12'h050, 32'h11112222);
        wait_hs(1, h);
        chk("t5_req1_granted", 64'(h >= 0), 64'd1);
        wait_sig(3, 5, b);
        chk("t5_rsp_lat", 64'(b - h), 64'd2);
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/glb_cfg_arbiter.md
GLB_CFG_ARBITER -- requirements
Module: glb_cfg_arbiter

Interface
REQ-001 The block SHALL have parameter AXI_ADDR_WIDTH, default 12, the config address width.
REQ-002 The block SHALL have parameter AXI_DATA_WIDTH, default 32, the config data width.
REQ-003 The block SHALL have parameter RD_TIMEOUT, default 64, the read-response timeout in cycles (legal values 2..1024).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port req_vld, input, 2 bits: per-requester request valid (index 0 = glc, index 1 = jtag).
REQ-007 The block SHALL have port req_rdy, output, 2 bits: per-requester request accept.
REQ-008 The block SHALL have port req_wr, input, 2 bits: 1 = write, 0 = read.
REQ-009 The block SHALL have port req_addr, input, 2 x AXI_ADDR_WIDTH bits: request address.
REQ-010 The block SHALL have port req_wdata, input, 2 x AXI_DATA_WIDTH bits: write data.
REQ-011 The block SHALL have port rsp_vld, output, 2 bits: one-cycle response pulse to the owning requester.
REQ-012 The block SHALL have port rsp_rdata, output, AXI_DATA_WIDTH bits: read data, qualified by rsp_vld.
REQ-013 The block SHALL have port rsp_err, output, 1 bit: timeout error, qualified by rsp_vld.
REQ-014 The block SHALL have ports if_cfg_wr_en, if_cfg_wr_clk_en, if_cfg_rd_en and if_cfg_rd_clk_en, all outputs, 1 bit each: the GLB config strobes and clock enables.
REQ-015 The block SHALL have ports if_cfg_wr_addr and if_cfg_rd_addr, outputs, AXI_ADDR_WIDTH bits, and if_cfg_wr_data, output, AXI_DATA_WIDTH bits.
REQ-016 The block SHALL have ports if_cfg_rd_data, input, AXI_DATA_WIDTH bits, and if_cfg_rd_data_valid, input, 1 bit: the GLB read return.

Function
REQ-017 The FSM SHALL have states IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT and RESP, with exactly one transaction in flight.
REQ-018 In IDLE, req_rdy SHALL be combinational and one-hot to the granted valid requester; in all other states req_rdy SHALL be 0.
REQ-019 Arbitration SHALL be round-robin: the requester not granted last has priority; a lone valid requester is always granted.
REQ-020 On a handshake, the block SHALL capture the owner, wr, addr and wdata and go to WR_ISSUE if wr=1, else to RD_ISSUE.
REQ-021 In WR_ISSUE, the registered outputs SHALL drive if_cfg_wr_en=1 for exactly one cycle with the captured addr and data; next state RESP.
REQ-022 if_cfg_wr_clk_en SHALL be 1 during WR_ISSUE and the following RESP cycle, and 0 otherwise.
REQ-023 In RD_ISSUE, the block SHALL drive if_cfg_rd_en=1 for one cycle with the captured address; next state RD_WAIT.
REQ-024 if_cfg_rd_clk_en SHALL be 1 from RD_ISSUE through the cycle in which the read completes.
REQ-025 if_cfg_rd_data_valid sampled in RD_ISSUE or RD_WAIT SHALL capture if_cfg_rd_data and move to RESP; outside those states it SHALL be ignored (late returns discarded).
REQ-026 In RESP, the block SHALL assert rsp_vld[owner] for one cycle with the captured rdata and err (write: rdata=0, err=0), then return to IDLE.
REQ-027 Latency SHALL be: write, handshake to rsp_vld = 2 cycles; read, rd_data_valid to rsp_vld = 1 cycle.
REQ-028 The if_cfg address and data outputs SHALL hold their last values when not strobed.

Reset
REQ-029 Reset SHALL force IDLE and set every output and register to 0, with the round-robin pointer giving requester 0 priority.
REQ-030 A transaction in flight at reset SHALL be dropped without a response, and no strobe SHALL be issued after reset deasserts until a new handshake.

Configuration
REQ-031 With macro GLB_CFG_ARB_TIMEOUT_EN defined, a counter SHALL count RD_WAIT cycles; RD_TIMEOUT cycles without valid SHALL go to RESP with rdata=0 and err=1, and a valid arriving in the timeout cycle SHALL win (err=0).
REQ-032 Without GLB_CFG_ARB_TIMEOUT_EN, there SHALL be no counter, RD_WAIT SHALL wait indefinitely, and rsp_err SHALL be tied to 0.

Verification
REQ-033 The bench SHALL cover: req0 write addr=0x010 data=0xA5A5A5A5 -> if_cfg_wr_en pulses 1 cycle after handshake with that addr/data, and rsp_vld[0] follows 1 cycle later with err=0.
REQ-034 The bench SHALL cover: req1 read addr=0x020, rd_data_valid 3 cycles after rd_en with data 0x12345678 -> rsp_vld[1] 1 cycle later with rdata=0x12345678, and rd_clk_en high throughout.
REQ-035 The bench SHALL cover: both requesters holding req_vld continuously for 4 transactions -> grant order 0,1,0,1, and no req_rdy asserted outside IDLE.
REQ-036 The bench SHALL cover, with the macro and RD_TIMEOUT=8: a read that is never answered -> rsp_vld after 8 RD_WAIT cycles with err=1 and rdata=0; a later stray rd_data_valid is ignored.
REQ-037 The bench SHALL cover: reset asserted during RD_WAIT -> all outputs 0 immediately, no rsp_vld, and the next request from requester 1 alone is granted.
